// File: rtl/if_id_skid_buffer.sv
// Fetch-to-decode stage: 2-entry FIFO skid buffer with valid/ready on both sides.
// Immediate format is classified at enqueue so decode sees a registered select.
module if_id_skid_buffer #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [XLEN-1:0] InstrF,
  input  logic [XLEN-1:0] PCF,
  input  logic            ValidF,
  output logic            ReadyF,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic [24:0]     ImmD,
  output logic [2:0]      ImmSrcD,
  output logic            IllegalD,
  output logic            ValidD,
  input  logic            ReadyD,
  output logic [1:0]      Count
);

  logic [XLEN-1:0] instr_q   [2];
  logic [XLEN-1:0] pc_q      [2];
  logic [2:0]      imm_src_q [2];
  logic            illegal_q [2];

  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;

  logic       push, pop;
  logic [2:0] imm_src_in;
  logic       illegal_in;

  assign ReadyF = (count_q != 2'd2);
  assign ValidD = (count_q != 2'd0);
  assign push   = ValidF & ReadyF;
  assign pop    = ValidD & ReadyD;
  assign Count  = count_q;

  always_comb begin
    imm_src_in = 3'b111;
    illegal_in = 1'b0;
    unique case (InstrF[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: imm_src_in = 3'b000;
      7'b0110111, 7'b0010111:             imm_src_in = 3'b001;
      7'b0100011:                         imm_src_in = 3'b010;
      7'b1100011:                         imm_src_in = 3'b011;
      7'b1101111:                         imm_src_in = 3'b100;
      7'b0110011, 7'b1110011:             imm_src_in = 3'b111;
      default:                            illegal_in = 1'b1;
    endcase
  end

  // Flush wins over push and pop; a popped head is simply discarded with the rest.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      instr_q[wr_ptr_q]   <= InstrF;
      pc_q[wr_ptr_q]      <= PCF;
      imm_src_q[wr_ptr_q] <= imm_src_in;
      illegal_q[wr_ptr_q] <= illegal_in;
    end
  end

  assign InstrD   = ValidD ? instr_q[rd_ptr_q]   : NOP_INSTR;
  assign PCD      = ValidD ? pc_q[rd_ptr_q]      : '0;
  assign ImmSrcD  = ValidD ? imm_src_q[rd_ptr_q] : 3'b000;
  assign IllegalD = ValidD ? illegal_q[rd_ptr_q] : 1'b0;
  assign PCPlus4D = PCD + XLEN'(4);
  assign ImmD     = InstrD[31:7];

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// Bench for if_id_skid_buffer: directed vector table, hand sequences and a
// randomized run against a queue-based reference model.
module tb_if_id_skid_buffer;

  logic        clk = 1'b0;
  logic        rst, flush, ValidF, ReadyF, ReadyD;
  logic [31:0] InstrF, PCF, InstrD, PCD, PCPlus4D;
  logic [24:0] ImmD;
  logic [2:0]  ImmSrcD;
  logic        IllegalD, ValidD;
  logic [1:0]  Count;

  int n_cmp = 0;
  int n_bad = 0;

  if_id_skid_buffer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .InstrF(InstrF), .PCF(PCF), .ValidF(ValidF), .ReadyF(ReadyF),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmD(ImmD),
    .ImmSrcD(ImmSrcD), .IllegalD(IllegalD), .ValidD(ValidD),
    .ReadyD(ReadyD), .Count(Count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, flush, validf;
    logic [31:0] instr, pc;
    logic        readyd;
    logic        e_validd;
    logic [1:0]  e_count;
    logic        e_readyf;
    logic [31:0] e_instr, e_pcp4;
    logic [2:0]  e_src;
    logic        e_ill;
  } vec_t;

  typedef struct {
    logic [31:0] instr, pc;
  } entry_t;

  vec_t   tbl[$];
  entry_t model_q[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Immediate-format and legality derived straight from the opcode table.
  function automatic logic [3:0] classify(input logic [31:0] instr);
    case (instr[6:0])
      7'h13, 7'h03, 7'h67: return 4'b0_000;
      7'h37, 7'h17:        return 4'b0_001;
      7'h23:               return 4'b0_010;
      7'h63:               return 4'b0_011;
      7'h6F:               return 4'b0_100;
      7'h33, 7'h73:        return 4'b0_111;
      default:             return 4'b1_111;
    endcase
  endfunction

  task automatic check_all(input string tag, input logic e_validd, input logic [1:0] e_count,
                           input logic e_readyf, input logic [31:0] e_instr,
                           input logic [31:0] e_pcp4, input logic [2:0] e_src, input logic e_ill);
    logic [31:0] ei;
    ei = e_instr;
    cmp({tag, ".ValidD"},   32'(ValidD),   32'(e_validd));
    cmp({tag, ".Count"},    32'(Count),    32'(e_count));
    cmp({tag, ".ReadyF"},   32'(ReadyF),   32'(e_readyf));
    cmp({tag, ".InstrD"},   InstrD,        e_instr);
    cmp({tag, ".PCPlus4D"}, PCPlus4D,      e_pcp4);
    cmp({tag, ".ImmD"},     32'(ImmD),     32'(ei[31:7]));
    cmp({tag, ".ImmSrcD"},  32'(ImmSrcD),  32'(e_src));
    cmp({tag, ".IllegalD"}, 32'(IllegalD), 32'(e_ill));
  endtask

  task automatic model_check(input string tag);
    logic [3:0]  cl;
    logic [31:0] ei, ep;
    if (model_q.size() != 0) begin
      ei = model_q[0].instr;
      ep = model_q[0].pc;
      cl = classify(ei);
    end else begin
      ei = 32'h00000013;
      ep = 32'h0;
      cl = 4'b0_000;
    end
    cmp({tag, ".PCD"}, PCD, ep);
    check_all(tag, model_q.size() != 0, 2'(model_q.size()), model_q.size() != 2,
              ei, ep + 32'd4, cl[2:0], cl[3]);
  endtask

  // Advance one cycle and update the reference model from the pre-edge inputs.
  task automatic model_step();
    bit push, pop;
    entry_t e;
    push = ValidF && (model_q.size() != 2);
    pop  = ReadyD && (model_q.size() != 0);
    @(posedge clk);
    #1;
    if (rst || flush) begin
      model_q.delete();
    end else begin
      if (pop) void'(model_q.pop_front());
      if (push) begin
        e.instr = InstrF;
        e.pc    = PCF;
        model_q.push_back(e);
      end
    end
  endtask

  localparam logic [31:0] NOP = 32'h00000013;

  initial begin
    logic [31:0] opc_list [10];
    int          sel;

    //            rst flush vf instr          pc             rdyD | vD cnt rF e_instr        e_pcp4        src    ill
    tbl.push_back('{1'b1,1'b0,1'b1,32'hFFF00093,32'h00000100,1'b0, 1'b0,2'd0,1'b1,NOP,          32'h4,        3'b000,1'b0});
    tbl.push_back('{1'b1,1'b0,1'b1,32'hFFF00093,32'h00000100,1'b0, 1'b0,2'd0,1'b1,NOP,          32'h4,        3'b000,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b1,32'hFFF00093,32'h00000100,1'b1, 1'b1,2'd1,1'b1,32'hFFF00093, 32'h104,      3'b000,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b0,32'hFFF00093,32'h00000100,1'b1, 1'b0,2'd0,1'b1,NOP,          32'h4,        3'b000,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b1,32'h00C000EF,32'h00000010,1'b0, 1'b1,2'd1,1'b1,32'h00C000EF, 32'h14,       3'b100,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b1,32'hFE208EE3,32'h00000014,1'b0, 1'b1,2'd2,1'b0,32'h00C000EF, 32'h14,       3'b100,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b1,32'h12345037,32'h00000018,1'b1, 1'b1,2'd1,1'b1,32'hFE208EE3, 32'h18,       3'b011,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b1,32'h12345037,32'h00000018,1'b1, 1'b1,2'd1,1'b1,32'h12345037, 32'h1C,       3'b001,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b1,32'h0000007F,32'hFFFFFFFC,1'b0, 1'b1,2'd2,1'b0,32'h12345037, 32'h1C,       3'b001,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b1,32'h0000007F,32'hFFFFFFFC,1'b1, 1'b1,2'd1,1'b1,32'h0000007F, 32'h0,        3'b111,1'b1});
    tbl.push_back('{1'b0,1'b0,1'b1,32'h00000033,32'h00000020,1'b0, 1'b1,2'd2,1'b0,32'h0000007F, 32'h0,        3'b111,1'b1});
    tbl.push_back('{1'b0,1'b1,1'b1,32'h00000013,32'h00000200,1'b1, 1'b0,2'd0,1'b1,NOP,          32'h4,        3'b000,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b0,32'h00000013,32'h00000200,1'b1, 1'b0,2'd0,1'b1,NOP,          32'h4,        3'b000,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b1,32'h00500113,32'h00000040,1'b0, 1'b1,2'd1,1'b1,32'h00500113, 32'h44,       3'b000,1'b0});
    tbl.push_back('{1'b1,1'b1,1'b1,32'h00000023,32'h00000044,1'b0, 1'b0,2'd0,1'b1,NOP,          32'h4,        3'b000,1'b0});

    rst = 1'b1; flush = 1'b0; ValidF = 1'b0; ReadyD = 1'b0; InstrF = '0; PCF = '0;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      rst    = tbl[i].rst;
      flush  = tbl[i].flush;
      ValidF = tbl[i].validf;
      InstrF = tbl[i].instr;
      PCF    = tbl[i].pc;
      ReadyD = tbl[i].readyd;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), tbl[i].e_validd, tbl[i].e_count, tbl[i].e_readyf,
                tbl[i].e_instr, tbl[i].e_pcp4, tbl[i].e_src, tbl[i].e_ill);
    end

    // Streaming: one instruction per cycle, occupancy pinned at 1.
    rst = 1'b0; flush = 1'b0; ValidF = 1'b1; ReadyD = 1'b1;
    for (int k = 0; k < 8; k++) begin
      InstrF = {12'(k), 5'd0, 3'b000, 5'd1, 7'b0010011};
      PCF    = 32'(k * 4);
      @(posedge clk);
      #1;
      cmp($sformatf("stream%0d.PCD", k),   PCD,         32'(k * 4));
      cmp($sformatf("stream%0d.Count", k), 32'(Count),  32'd1);
      cmp($sformatf("stream%0d.InstrD", k), InstrD, {12'(k), 5'd0, 3'b000, 5'd1, 7'b0010011});
    end
    ValidF = 1'b0;
    @(posedge clk);
    #1;
    cmp("stream_drain.ValidD", 32'(ValidD), 32'd0);

    // Randomized run against the queue model.
    opc_list = '{32'h13, 32'h03, 32'h67, 32'h37, 32'h17, 32'h23, 32'h63, 32'h6F, 32'h33, 32'h7F};
    rst = 1'b1; ValidF = 1'b0; ReadyD = 1'b0;
    model_step();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      // Upstream keeps its offer stable while it is not accepted.
      if (!(ValidF && model_q.size() == 2)) begin
        ValidF = ($urandom_range(0, 3) != 0);
        sel    = $urandom_range(0, 10);
        InstrF = {$urandom_range(0, 32'h1FFFFFF), 7'h00};
        InstrF[6:0] = (sel == 10) ? 7'($urandom) : opc_list[sel][6:0];
        PCF    = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
      end
      ReadyD = ($urandom_range(0, 2) != 0);
      flush  = ($urandom_range(0, 19) == 0);
      rst    = ($urandom_range(0, 199) == 0);
      model_step();
      model_check($sformatf("rand%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_id_skid_buffer.md
Name: if_id_skid_buffer

Overview:
- Fetch-to-decode pipeline stage.
- Holds up to two fetched instructions in a 2-entry FIFO skid buffer, with valid/ready handshakes on both sides.
- Classifies each instruction's immediate format at enqueue time.
- Presents the head entry to decode: PC, PC+4, the instruction bits [31:7] and the 3-bit immediate-format select consumed directly by the downstream sign-extension unit.

Parameters:
- XLEN, 32, data/address width.
- NOP_INSTR, 32'h00000013, value driven on InstrD whenever ValidD=0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all buffered entries (branch/jump redirect).
- InstrF  in  XLEN  fetched instruction.
- PCF  in  XLEN  PC of InstrF.
- ValidF  in  1  InstrF/PCF valid.
- ReadyF  out  1  buffer can accept this cycle.
- InstrD  out  XLEN  head instruction.
- PCD  out  XLEN  head PC.
- PCPlus4D  out  XLEN  head PC + 4.
- ImmD  out  25  head instruction bits [31:7], for sign extension.
- ImmSrcD  out  3  head immediate format.
- IllegalD  out  1  head opcode unrecognised.
- ValidD  out  1  head entry valid.
- ReadyD  in  1  decode accepts head this cycle.
- Count  out  2  occupancy, 0..2.

Behaviour:
- Storage: two entries, each holding {Instr, PC, ImmSrc, Illegal}. Read pointer, write pointer (1 bit each) and a 2-bit count, all registered.
- Handshakes:
  - Push occurs when ValidF & ReadyF. Pop occurs when ValidD & ReadyD.
  - ReadyF = (Count != 2), combinational from registered Count only; it must not depend on ReadyD (no combinational ready path).
  - ValidD = (Count != 0).
- Latency: an entry pushed at edge N appears on the outputs after edge N (1 cycle) if the buffer was empty; order is strictly FIFO.
- Simultaneous push and pop:
  - Count = 1: push and pop both occur; Count stays 1.
  - Count = 2: no push is possible (ReadyF=0). A pop makes ReadyF=1 only in the following cycle.
  - Count = 0: no pop is possible; only the push occurs.
- Output holding: when ValidD=1 and ReadyD=0, all D outputs are held stable until accepted. When ValidF=1 and ReadyF=0, the upstream stage holds its inputs (upstream obligation).
- PCPlus4D = PCD + 4, modulo 2^XLEN (wraps from 0xFFFFFFFC to 0).
- Empty buffer (ValidD=0): InstrD=NOP_INSTR, ImmD=NOP_INSTR[31:7], PCD=0, PCPlus4D=4, ImmSrcD=3'b000, IllegalD=0.
- ImmSrc classification, computed from InstrF[6:0] at push:
  - 0010011, 0000011, 1100111 -> 000 (I).
  - 0110111, 0010111 -> 001 (U).
  - 0100011 -> 010 (S).
  - 1100011 -> 011 (B).
  - 1101111 -> 100 (J).
  - 0110011, 1110011 -> 111 (no immediate; the sign-extension unit outputs 0).
  - Any other opcode -> 111 with Illegal=1.
- Flush:
  - Next cycle Count=0 and pointers reset to 0.
  - Flush beats a same-cycle push (the incoming instruction is dropped) and a same-cycle pop (the pop is still considered accepted by decode).
  - ReadyF is unaffected during the flush cycle.
- Reset: Count=0, pointers=0, entry contents don't-care; outputs take the empty values above. Reset mid-operation behaves as flush and overrides flush.

Test Plan:
- Reset: hold rst 2 cycles with ValidF=1 -> ValidD=0, ReadyF=1, Count=0, InstrD=0x00000013, PCPlus4D=4.
- Single push: InstrF=0xFFF00093 (addi), PCF=0x100, ReadyD=1 -> next cycle ValidD=1, PCD=0x100, PCPlus4D=0x104, ImmSrcD=000, ImmD=0xFFF00093>>7; popped, Count=0 after.
- Back-pressure: ReadyD=0; push 0x00C000EF (jal), then 0xFE208EE3 (beq) -> Count=2, ReadyF=0, head ImmSrcD=100. Raise ReadyD -> beq emerges next with ImmSrcD=011, order preserved.
- Streaming: ValidF=ReadyD=1 for 8 cycles, PCs 0x0..0x1C -> Count stays 1, one instruction per cycle, no gaps or duplicates.
- Flush with push: Count=2, then flush=1 together with ValidF=1 (PCF=0x200) -> next cycle Count=0, ValidD=0; 0x200 is never output.
- Classification: push 0x12345037 (lui) -> ImmSrcD=001, IllegalD=0; push 0x0000007F -> ImmSrcD=111, IllegalD=1; PCF=0xFFFFFFFC -> PCPlus4D=0.
